// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps at most one imem request in flight and buffers
// returned words for decode. Optional FETCH_ALIGN_CHECK_EN adds a sticky misaligned-redirect fault.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        fetch_fault
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_req_pc;
  logic            r_outstanding;
  logic            r_drop;
  logic            r_fault;
  logic [31:0]     r_q_pc    [DEPTH];
  logic [31:0]     r_q_instr [DEPTH];
  logic [CntW-1:0] r_count;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;

  logic [31:0]     w_redir_pc;
  logic            w_redir_bad;
  logic            w_accept;
  logic            w_deq;
  logic            w_issue;
  logic [CntW:0]   w_occ;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redir_pc  = redirect_pc;
  assign w_redir_bad = (redirect_pc[1:0] != 2'b00);
`else
  assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
  assign w_redir_bad = 1'b0;
`endif

  assign w_accept = imem_rvalid && r_outstanding && !r_drop && !redirect_valid;
  assign w_deq    = id_valid && id_ready;
  // Occupancy as it will be after this cycle, so a slot freed by decode can be refilled at once.
  assign w_occ    = {1'b0, r_count} + (CntW+1)'(w_accept) - (CntW+1)'(w_deq);
  assign w_issue  = !redirect_valid && !r_fault && (!r_outstanding || imem_rvalid) &&
                    (w_occ < (CntW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= RESET_PC;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
      r_fault       <= 1'b0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redir_pc;
      r_fault       <= w_redir_bad;
      // A request still in flight must be allowed to return and be discarded.
      r_outstanding <= r_outstanding && !imem_rvalid;
      r_drop        <= r_outstanding && !imem_rvalid;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      if (w_issue) begin
        r_req_pc      <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_outstanding <= 1'b1;
      end else if (imem_rvalid) begin
        r_outstanding <= 1'b0;
      end
      if (imem_rvalid && r_outstanding) begin
        r_drop <= 1'b0;
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_accept) - CntW'(w_deq);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_q_pc[r_wr_ptr]    <= r_req_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req    = rst && w_issue;
  assign imem_addr   = r_fetch_pc;
  assign id_valid    = (r_count != '0);
  assign id_instr    = id_valid ? r_q_instr[r_rd_ptr] : Nop;
  assign id_pc       = id_valid ? r_q_pc[r_rd_ptr] : 32'h0000_0000;
  assign fetch_fault = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency memory and decode, with a scoreboard of expected
// {pc, instr} entries derived from sequential fetch, redirects and discarded responses.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        fetch_fault;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus knobs
  logic        g_ready, g_redir, g_stray_en;
  logic [31:0] g_redir_pc;
  int          g_lat_min, g_lat_max;

  // reference model state
  ent_t        m_q[$];
  logic        m_pend, m_stale, m_fault, m_stray_once;
  int          m_cnt;
  logic [31:0] m_addr, m_fetch;
  logic        m_watch, m_watch_deq, m_saw_zero;
  logic [31:0] m_first_req, m_first_deq;
  logic [31:0] d_log[$];
  int          n_deq, n_req;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive just after a negedge, sample 1ns later, update model, wait next negedge.
  task automatic step();
    logic resp, acc, deq, exp_req;
    int   occ;
    resp = 1'b0;
    if (m_pend) begin
      if (m_cnt == 0) resp = 1'b1;
      else m_cnt--;
    end
    imem_rvalid = resp;
    imem_rdata  = resp ? (m_addr ^ 32'hA5A5_0000) : $urandom();
    if (!m_pend && (m_stray_once || (g_stray_en && $urandom_range(0, 15) == 0)))
      imem_rvalid = 1'b1;
    m_stray_once   = 1'b0;
    id_ready       = g_ready;
    redirect_valid = g_redir;
    redirect_pc    = g_redir_pc;
    #1;
    check("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    check("id_valid", {31'b0, id_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      check("id_pc", id_pc, m_q[0].pc);
      check("id_instr", id_instr, m_q[0].instr);
    end else begin
      check("id_pc_empty", id_pc, 32'h0);
      check("id_instr_empty", id_instr, 32'h0000_0013);
    end
    check("imem_addr", imem_addr, m_fetch);
    deq     = (m_q.size() != 0) && g_ready;
    acc     = resp && !m_stale && !g_redir;
    occ     = m_q.size() + int'(acc) - int'(deq);
    exp_req = !g_redir && !m_fault && (!m_pend || resp) && (occ < DEPTH);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});

    if (resp) begin
      m_pend  = 1'b0;
      m_stale = 1'b0;
    end
    if (g_redir) begin
      m_q.delete();
      if (m_pend) m_stale = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
      m_fault = (g_redir_pc[1:0] != 2'b00);
      m_fetch = g_redir_pc;
`else
      m_fetch = g_redir_pc & 32'hFFFF_FFFC;
`endif
    end else begin
      if (deq) begin
        d_log.push_back(m_q[0].pc);
        n_deq++;
        if (m_watch_deq) begin
          m_first_deq = m_q[0].pc;
          m_watch_deq = 1'b0;
        end
        void'(m_q.pop_front());
      end
      if (acc) m_q.push_back('{pc: m_addr, instr: m_addr ^ 32'hA5A5_0000});
      if (exp_req) begin
        m_pend  = 1'b1;
        m_stale = 1'b0;
        m_addr  = m_fetch;
        m_cnt   = $urandom_range(g_lat_min, g_lat_max) - 1;
        n_req++;
        if (m_fetch == 32'h0) m_saw_zero = 1'b1;
        if (m_watch) begin
          m_first_req = m_fetch;
          m_watch     = 1'b0;
        end
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(input logic [31:0] pc);
    g_redir     = 1'b1;
    g_redir_pc  = pc;
    m_watch     = 1'b1;
    m_watch_deq = 1'b1;
    m_first_req = 32'hDEAD_BEEF;
    m_first_deq = 32'hDEAD_BEEF;
    step();
    g_redir     = 1'b0;
  endtask

  // Asynchronous reset asserted between edges, followed by a late stray response.
  task automatic do_reset();
    #2;
    rst            = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    m_q.delete();
    d_log.delete();
    m_pend = 1'b0; m_stale = 1'b0; m_fault = 1'b0;
    m_fetch = RESET_PC; n_deq = 0; n_req = 0;
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, RESET_PC);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_instr", id_instr, 32'h0000_0013);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_fault", {31'b0, fetch_fault}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    m_stray_once = 1'b1;
    rst          = 1'b1;
  endtask

  initial begin
    rst = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;
    g_ready = 1'b1; g_redir = 1'b0; g_redir_pc = '0; g_stray_en = 1'b0;
    g_lat_min = 1; g_lat_max = 1;
    m_stray_once = 1'b0; m_watch = 1'b0; m_watch_deq = 1'b0; m_saw_zero = 1'b0;
    m_cnt = 0; m_addr = '0;
    @(negedge clk);

    // Streaming with 1-cycle memory: one instruction per cycle.
    do_reset();
    run(10);
    check("stream_deq_count", n_deq, 8);
    check("stream_pc0", d_log[0], 32'h0);
    check("stream_pc1", d_log[1], 32'h4);
    check("stream_pc2", d_log[2], 32'h8);

    // Decode stalled: queue fills to DEPTH, then drains in order.
    do_reset();
    g_ready = 1'b0;
    run(6);
    check("stall_req_count", n_req, DEPTH);
    g_ready = 1'b1;
    run(6);
    check("drain_pc0", d_log[0], 32'h0);
    check("drain_pc1", d_log[1], 32'h4);
    check("drain_pc2", d_log[2], 32'h8);

    // Redirect while the request for 0x8 is in flight, 3-cycle memory.
    do_reset();
    g_lat_min = 3; g_lat_max = 3;
    for (int i = 0; i < 30 && !(m_pend && m_addr == 32'h8); i++) step();
    check("inflight_0x8_seen", {31'b0, m_pend && m_addr == 32'h8}, 32'h1);
    redirect(32'h0000_0100);
    run(12);
    check("inflight_redir_addr", m_first_req, 32'h100);
    check("inflight_first_pc", m_first_deq, 32'h100);

    // Redirect coinciding with a response and a dequeue.
    do_reset();
    g_lat_min = 1; g_lat_max = 1;
    run(4);
    redirect(32'h0000_0100);
    step();
    check("same_cycle_req_addr", m_first_req, 32'h100);
    run(4);
    check("same_cycle_first_pc", m_first_deq, 32'h100);

    // PC wrap at the top of the address space.
    m_saw_zero = 1'b0;
    redirect(32'hFFFF_FFF8);
    run(6);
    check("wrap_to_zero", {31'b0, m_saw_zero}, 32'h1);

    // Misaligned redirect, then an aligned one.
    redirect(32'h0000_0102);
    run(4);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misaligned_fault", {31'b0, fetch_fault}, 32'h1);
    check("misaligned_no_req", m_first_req, 32'hDEAD_BEEF);
`else
    check("misaligned_masked", m_first_req, 32'h100);
`endif
    redirect(32'h0000_0200);
    run(4);
    check("aligned_fault_clear", {31'b0, fetch_fault}, 32'h0);
    check("aligned_req_addr", m_first_req, 32'h200);

    // Randomised traffic.
    g_stray_en = 1'b1;
    g_lat_min = 1; g_lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      g_ready = ($urandom_range(0, 9) < 7);
      g_redir = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       g_redir_pc = $urandom() & 32'hFFFF_FFFC;
        1:       g_redir_pc = $urandom();
        2:       g_redir_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: g_redir_pc = 32'h0000_1000;
      endcase
      if (i == 1500) g_ready = 1'b1;
      step();
    end
    g_redir = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
